// File: rtl/hazard_stall_controller_if.sv
// Pipeline-to-hazard-controller bundle: decode/execute/memory hazard inputs
// plus the stall/flush controls and the mul/div start/abort handshake.
interface hazard_stall_controller_if;
    logic [4:0] dec_rs;
    logic [4:0] dec_rt;
    logic       dec_use_rs;
    logic       dec_use_rt;
    logic       dec_read_hilo;
    logic       dec_muldiv;
    logic       dec_is_div;
    logic [4:0] ex_dest_reg;
    logic       ex_write_reg;
    logic       ex_load;
    logic       mem_exception;

    logic       stall_fetch;
    logic       stall_decode;
    logic       bubble_execute;
    logic       flush_all;
    logic       md_start;
    logic       md_is_div;
    logic       md_abort;
    logic       md_busy;

    // The pipeline drives the hazard sources and consumes the controls.
    modport master (
        output dec_rs, dec_rt, dec_use_rs, dec_use_rt, dec_read_hilo,
               dec_muldiv, dec_is_div, ex_dest_reg, ex_write_reg, ex_load,
               mem_exception,
        input  stall_fetch, stall_decode, bubble_execute, flush_all,
               md_start, md_is_div, md_abort, md_busy
    );

    modport slave (
        input  dec_rs, dec_rt, dec_use_rs, dec_use_rt, dec_read_hilo,
               dec_muldiv, dec_is_div, ex_dest_reg, ex_write_reg, ex_load,
               mem_exception,
        output stall_fetch, stall_decode, bubble_execute, flush_all,
               md_start, md_is_div, md_abort, md_busy
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Detects load-use and mul/div-busy hazards, drives stall/bubble/flush, and
// sequences the multi-cycle mul/div unit including exception aborts.
module hazard_stall_controller #(
    parameter int MUL_LATENCY = 4,
    parameter int DIV_LATENCY = 32,
    parameter int CNT_W       = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    hazard_stall_controller_if.slave   bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       age, age_nxt;
    logic             reset_q;
    logic             hold;
    logic             busy;
    logic             load_use;
    logic             md_hazard;

    // Outputs stay quiet during reset and the cycle right after it.
    assign hold = reset | reset_q;
    assign busy = !hold && (state == BUSY);

    assign load_use = bus.ex_load && bus.ex_write_reg && (bus.ex_dest_reg != 5'd0) &&
                      ((bus.dec_use_rs && (bus.dec_rs == bus.ex_dest_reg)) ||
                       (bus.dec_use_rt && (bus.dec_rt == bus.ex_dest_reg)));

    assign md_hazard = busy && (bus.dec_read_hilo || bus.dec_muldiv);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        reset_q <= reset;
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            age   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            age   <= age_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_nxt          = state;
        cnt_nxt            = cnt;
        age_nxt            = age;
        bus.stall_fetch    = 1'b0;
        bus.stall_decode   = 1'b0;
        bus.bubble_execute = 1'b0;
        bus.flush_all      = 1'b0;
        bus.md_start       = 1'b0;
        bus.md_is_div      = 1'b0;
        bus.md_abort       = 1'b0;
        bus.md_busy        = 1'b0;

        if (!hold) begin
            if (bus.mem_exception) begin
                bus.flush_all = 1'b1;
            end else if (md_hazard || load_use) begin
                bus.stall_fetch    = 1'b1;
                bus.stall_decode   = 1'b1;
                bus.bubble_execute = 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.dec_muldiv && !load_use && !bus.mem_exception) begin
                        bus.md_start  = 1'b1;
                        bus.md_is_div = bus.dec_is_div;
                        cnt_nxt       = bus.dec_is_div ? DIV_LOAD : MUL_LOAD;
                        age_nxt       = 2'd0;
                        state_nxt     = BUSY;
                    end
                end
                BUSY: begin
                    bus.md_busy = 1'b1;
                    // Age 0/1: the mul/div is in execute or memory, so it is
                    // not older than the faulting instruction and must die.
                    if (bus.mem_exception && (age <= 2'd1)) begin
                        bus.md_abort = 1'b1;
                        cnt_nxt      = '0;
                        age_nxt      = 2'd0;
                        state_nxt    = IDLE;
                    end else begin
                        age_nxt = (age == 2'd3) ? age : age + 2'd1;
                        if (cnt == '0) begin
                            state_nxt = IDLE;
                        end else begin
                            cnt_nxt = cnt - CNT_ONE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed-vector bench for hazard_stall_controller; expected output vectors
// are hand-computed constants per cycle.
module tb_hazard_stall_controller;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    hazard_stall_controller_if bus ();

    hazard_stall_controller #(
        .MUL_LATENCY (4),
        .DIV_LATENCY (32),
        .CNT_W       (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Output vector: {stall_fetch, stall_decode, bubble_execute, flush_all,
    //                 md_start, md_is_div, md_abort, md_busy}
    localparam logic [7:0] O_NONE   = 8'b0000_0000;
    localparam logic [7:0] O_STALL  = 8'b1110_0000;
    localparam logic [7:0] O_FLUSH  = 8'b0001_0000;
    localparam logic [7:0] O_MUL    = 8'b0000_1000;
    localparam logic [7:0] O_DIV    = 8'b0000_1100;
    localparam logic [7:0] O_BUSY   = 8'b0000_0001;
    localparam logic [7:0] O_BSTALL = 8'b1110_0001;
    localparam logic [7:0] O_BFLUSH = 8'b0001_0001;
    localparam logic [7:0] O_ABORT  = 8'b0001_0011;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] outs();
        return {bus.stall_fetch, bus.stall_decode, bus.bubble_execute, bus.flush_all,
                bus.md_start, bus.md_is_div, bus.md_abort, bus.md_busy};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs are set right after a negedge; outputs are checked 1ns later,
    // then the bench waits for the next negedge (crossing one posedge).
    task automatic cyc(input string tag, input logic [7:0] exp);
        #1 check(tag, outs(), exp);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.dec_rs        = 5'd0;
        bus.dec_rt        = 5'd0;
        bus.dec_use_rs    = 1'b0;
        bus.dec_use_rt    = 1'b0;
        bus.dec_read_hilo = 1'b0;
        bus.dec_muldiv    = 1'b0;
        bus.dec_is_div    = 1'b0;
        bus.ex_dest_reg   = 5'd0;
        bus.ex_write_reg  = 1'b0;
        bus.ex_load       = 1'b0;
        bus.mem_exception = 1'b0;
    endtask

    task automatic load_use_rt5();
        bus.ex_load      = 1'b1;
        bus.ex_write_reg = 1'b1;
        bus.ex_dest_reg  = 5'd5;
        bus.dec_use_rt   = 1'b1;
        bus.dec_rt       = 5'd5;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        clear_inputs();
        @(negedge clk);

        // Reset cycle and the following cycle stay silent under hostile inputs.
        load_use_rt5();
        bus.dec_muldiv    = 1'b1;
        bus.dec_read_hilo = 1'b1;
        cyc("reset_cycle", O_NONE);
        reset = 1'b0;
        cyc("post_reset_cycle", O_NONE);
        bus.mem_exception = 1'b1;
        bus.dec_muldiv    = 1'b0;
        clear_inputs();
        cyc("idle_quiet", O_NONE);

        // Load-use on rt, then the load moves on.
        load_use_rt5();
        cyc("load_use_rt", O_STALL);
        clear_inputs();
        cyc("load_use_release", O_NONE);
        load_use_rt5();
        bus.ex_dest_reg = 5'd0;
        bus.dec_rt      = 5'd0;
        cyc("load_use_r0", O_NONE);
        load_use_rt5();
        bus.dec_use_rt = 1'b0;
        bus.dec_use_rs = 1'b1;
        bus.dec_rs     = 5'd5;
        cyc("load_use_rs", O_STALL);
        bus.dec_use_rs = 1'b0;
        cyc("load_use_unused", O_NONE);
        load_use_rt5();
        bus.ex_load = 1'b0;
        cyc("no_load_alu_dep", O_NONE);
        load_use_rt5();
        bus.dec_rt = 5'd6;
        cyc("load_use_diff_reg", O_NONE);

        // Mul/div held back by load-use, then issues once the load has moved.
        load_use_rt5();
        bus.dec_muldiv = 1'b1;
        cyc("muldiv_blocked_by_load", O_STALL);
        clear_inputs();
        bus.dec_muldiv = 1'b1;
        cyc("mul_after_load", O_MUL);
        clear_inputs();
        bus.dec_read_hilo = 1'b1;
        for (int i = 1; i <= 4; i++) cyc($sformatf("mflo_stall_%0d", i), O_BSTALL);
        cyc("mflo_release", O_NONE);
        clear_inputs();

        // Back-to-back divides: busy 32 cycles, second start right after.
        bus.dec_muldiv = 1'b1;
        bus.dec_is_div = 1'b1;
        cyc("div1_start", O_DIV);
        for (int i = 1; i <= 32; i++) cyc($sformatf("div1_busy_%0d", i), O_BSTALL);
        cyc("div2_start", O_DIV);
        clear_inputs();
        for (int i = 1; i <= 32; i++) cyc($sformatf("div2_busy_%0d", i), O_BUSY);
        cyc("div2_done", O_NONE);

        // Exception at age 1 aborts the multiply; a new mul then starts at once.
        bus.dec_muldiv = 1'b1;
        cyc("abort_mul_start", O_MUL);
        clear_inputs();
        cyc("abort_age0", O_BUSY);
        bus.mem_exception = 1'b1;
        cyc("abort_age1", O_ABORT);
        clear_inputs();
        bus.dec_muldiv = 1'b1;
        cyc("restart_after_abort", O_MUL);
        clear_inputs();
        // Exception at age 3 does not abort; the mul completes.
        for (int i = 1; i <= 3; i++) cyc($sformatf("noabort_busy_%0d", i), O_BUSY);
        bus.mem_exception = 1'b1;
        cyc("noabort_age3", O_BFLUSH);
        clear_inputs();
        cyc("noabort_done", O_NONE);

        // Exception at age 0 also aborts.
        bus.dec_muldiv = 1'b1;
        cyc("abort0_start", O_MUL);
        clear_inputs();
        bus.mem_exception = 1'b1;
        cyc("abort_at_age0", O_ABORT);
        clear_inputs();
        cyc("abort0_idle", O_NONE);

        // Exception in IDLE suppresses a start.
        bus.dec_muldiv    = 1'b1;
        bus.mem_exception = 1'b1;
        cyc("exc_suppress_start", O_FLUSH);
        clear_inputs();
        cyc("exc_no_busy", O_NONE);

        // Priority: exception beats md_hazard and load_use (age 2, no abort).
        bus.dec_muldiv = 1'b1;
        cyc("prio_mul_start", O_MUL);
        clear_inputs();
        cyc("prio_busy_1", O_BUSY);
        cyc("prio_busy_2", O_BUSY);
        load_use_rt5();
        bus.dec_read_hilo = 1'b1;
        bus.mem_exception = 1'b1;
        cyc("prio_all_hazards", O_BFLUSH);
        clear_inputs();
        cyc("prio_busy_last", O_BUSY);
        cyc("prio_done", O_NONE);

        // Reset in busy cycle 10 of a divide, then a fresh divide.
        bus.dec_muldiv = 1'b1;
        bus.dec_is_div = 1'b1;
        cyc("rdiv_start", O_DIV);
        clear_inputs();
        for (int i = 1; i <= 9; i++) cyc($sformatf("rdiv_busy_%0d", i), O_BUSY);
        reset          = 1'b1;
        bus.dec_muldiv = 1'b1;
        bus.dec_is_div = 1'b1;
        cyc("rdiv_reset_cycle", O_NONE);
        reset = 1'b0;
        cyc("rdiv_hold_cycle", O_NONE);
        cyc("rdiv_new_start", O_DIV);
        clear_inputs();
        cyc("rdiv_new_busy", O_BUSY);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller that works alongside the forwarding unit.
- Detects hazards that forwarding cannot resolve: load-use dependencies, and hi/lo reads or new mul/div issued while the multi-cycle mul/div unit is busy.
- Drives the stall, bubble and flush controls for fetch, decode and execute.
- Owns the start/abort handshake of the mul/div unit.

Parameters:
- MUL_LATENCY, 4: total busy cycles for mult/multu, including the start cycle.
- DIV_LATENCY, 32: total busy cycles for div/divu, including the start cycle.
- CNT_W, 6: counter width; must satisfy 2^CNT_W > max(MUL_LATENCY, DIV_LATENCY).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- dec_rs  in  5  rs field of the decode-stage instruction.
- dec_rt  in  5  rt field of the decode-stage instruction.
- dec_use_rs  in  1  decode instruction reads rs.
- dec_use_rt  in  1  decode instruction reads rt.
- dec_read_hilo  in  1  decode instruction reads hi or lo (mfhi/mflo).
- dec_muldiv  in  1  decode instruction is mult/multu/div/divu.
- dec_is_div  in  1  qualifies dec_muldiv: 1 = div type.
- ex_dest_reg  in  5  destination GPR of the execute-stage instruction.
- ex_write_reg  in  1  execute instruction writes a GPR.
- ex_load  in  1  execute instruction is a load.
- mem_exception  in  1  instruction in the memory stage raises an exception.
- stall_fetch  out  1  hold the PC and the fetch/decode register.
- stall_decode  out  1  hold the decode/execute input.
- bubble_execute  out  1  inject a NOP into execute next cycle.
- flush_all  out  1  kill fetch, decode and execute contents.
- md_start  out  1  one-cycle start pulse to the mul/div unit.
- md_is_div  out  1  operation type, valid while md_start=1.
- md_abort  out  1  one-cycle abort pulse to the mul/div unit.
- md_busy  out  1  mul/div operation in flight.

Behaviour:
- Reset: state=IDLE, busy counter=0, age counter=0.
  - Every output is 0 in the cycle reset is sampled high and in the following cycle, regardless of inputs.
- load_use (combinational): ex_load & ex_write_reg & ex_dest_reg!=0 & ((dec_use_rs & dec_rs==ex_dest_reg) | (dec_use_rt & dec_rt==ex_dest_reg)).
- md_hazard (combinational): md_busy & (dec_read_hilo | dec_muldiv).
- Output priority is mem_exception, then md_hazard, then load_use.
  - mem_exception: flush_all=1; stall_fetch, stall_decode, bubble_execute=0.
  - md_hazard or load_use (no exception): stall_fetch=stall_decode=bubble_execute=1.
  - A load_use stall lasts exactly 1 cycle, because the load advances out of execute.
- FSM states: IDLE and BUSY.
- IDLE:
  - If dec_muldiv & !load_use & !mem_exception: md_start=1 and md_is_div=dec_is_div in the same cycle.
  - Load the counter with (dec_is_div ? DIV_LATENCY : MUL_LATENCY)-1, set age=0, go to BUSY.
- BUSY:
  - md_busy=1; the counter decrements each cycle; age increments and saturates at 3.
  - When the counter reaches 0, go to IDLE next cycle.
  - md_busy is high for exactly LATENCY cycles after the start cycle. md_busy is 0 in the start cycle itself.
- Stalled mul/div: a dec_muldiv that is stalled by md_hazard issues in the first IDLE cycle.
  - No idle gap is permitted between back-to-back operations.
- Abort rule, mem_exception while BUSY:
  - The mul/div instruction sits in execute when age=0 and in memory when age=1; in both cases it is the same as or younger than the faulting instruction.
  - If age<=1: md_abort=1 for one cycle, go to IDLE, counter=0.
  - If age>=2: the instruction is older, and the operation completes normally.
- mem_exception in IDLE in the same cycle as dec_muldiv: md_start is suppressed; no state change.
- ex_dest_reg=0 never causes a stall.
- md_start and md_abort are never both 1 in the same cycle.

Test Plan:
- Load-use: ex_load=1, ex_write_reg=1, ex_dest_reg=5, dec_use_rt=1, dec_rt=5 -> stall_fetch=stall_decode=bubble_execute=1 for 1 cycle; the same stimulus with ex_dest_reg=0 -> no stall.
- Multiply then read: dec_muldiv=1, dec_is_div=0 at cycle T -> md_start pulse at T; md_busy=1 for T+1..T+4. mflo at decode from T+1 -> stalled through T+4, released at T+5.
- Back-to-back divide: div at T, second div waiting in decode -> md_busy high T+1..T+32; second md_start at T+33 with md_is_div=1.
- Exception abort: mult issued at T, mem_exception at T+2 (age=1) -> md_abort=1 at T+2, flush_all=1, md_busy=0 at T+3. The same stimulus at T+4 (age=3) -> no abort; busy runs to T+4.
- Priority: mem_exception, load_use and md_hazard all true together -> flush_all=1, all stalls 0.
- Reset mid-divide: reset at busy cycle 10 -> the next cycle has all outputs 0 and state IDLE; a new div is accepted immediately afterwards.
